// File: rtl/fbuf_pkg.sv
// ---------------------------------------------------------------------------
// fbuf_pkg
// Shared constants for the ping-pong frame buffer: image geometry, address
// and pixel widths, and the controller state encoding.
// ---------------------------------------------------------------------------
package fbuf_pkg;

  localparam int C_IMG_COLS    = 80;
  localparam int C_IMG_ROWS    = 60;
  localparam int C_IMG_PXLS    = C_IMG_COLS * C_IMG_ROWS;  // 4800
  localparam int C_NB_IMG_PXLS = 13;                       // pixel address width in one bank
  localparam int C_NB_BUF      = 12;                       // RGB444 pixel word

  // Address of the final pixel of a frame within a bank
  localparam logic [C_NB_IMG_PXLS-1:0] C_LAST_PXL = C_NB_IMG_PXLS'(C_IMG_PXLS - 1);

  // Controller state encoding
  localparam logic [1:0] C_ST_WAIT_SOF = 2'd0;
  localparam logic [1:0] C_ST_CAPTURE  = 2'd1;
  localparam logic [1:0] C_ST_FULL     = 2'd2;

  typedef enum logic [1:0] {
    WAIT_SOF = C_ST_WAIT_SOF,
    CAPTURE  = C_ST_CAPTURE,
    FULL     = C_ST_FULL
  } fbuf_state_t;

endpackage

// File: rtl/fbuf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// fbuf_pingpong_ctrl
// Double-buffer controller between the camera capture path and the display
// read path. The camera fills one bank with a whole frame while the display
// reads the other; banks swap only at a display frame end that follows a
// complete camera frame, so the display never shows a torn image.
//
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   cam_sof      camera start-of-frame pulse
//   cam_we       camera pixel strobe, cam_pixel carries the data
//   disp_eof     display frame-end pulse
//   freeze       hold the displayed frame (present only with FBUF_FREEZE_EN)
//   wr_en/wr_addr/wr_data  registered write port of the dual-bank RAM,
//                wr_addr = {write bank, pixel address}
//   rd_bank      bank MSB used by the display read address
//   frame_swap   one-clock pulse when the banks swap
//   drop_cnt     saturating count of short/aborted camera frames
//
// Build option: define FBUF_FREEZE_EN to add the freeze input.
// ---------------------------------------------------------------------------
module fbuf_pingpong_ctrl
  import fbuf_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_sof,
  input  logic                     cam_we,
  input  logic [C_NB_BUF-1:0]      cam_pixel,
  input  logic                     disp_eof,
`ifdef FBUF_FREEZE_EN
  input  logic                     freeze,
`endif
  output logic                     wr_en,
  output logic [C_NB_IMG_PXLS:0]   wr_addr,
  output logic [C_NB_BUF-1:0]      wr_data,
  output logic                     rd_bank,
  output logic                     frame_swap,
  output logic [7:0]               drop_cnt
);

  fbuf_state_t              state_reg, state_next;
  logic [C_NB_IMG_PXLS-1:0] pixel_addr_reg, pixel_addr_next;
  logic                     rd_bank_reg, rd_bank_next;
  logic                     wr_en_reg, wr_en_next;
  logic [C_NB_IMG_PXLS:0]   wr_addr_reg, wr_addr_next;
  logic [C_NB_BUF-1:0]      wr_data_reg, wr_data_next;
  logic                     frame_swap_reg, frame_swap_next;
  logic [7:0]               drop_cnt_reg, drop_cnt_next;
  logic                     freeze_hold;

`ifdef FBUF_FREEZE_EN
  assign freeze_hold = freeze;
`else
  assign freeze_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= WAIT_SOF;
      pixel_addr_reg <= '0;
      rd_bank_reg    <= 1'b1;   // write bank starts at 0, display reads bank 1
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      frame_swap_reg <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pixel_addr_reg <= pixel_addr_next;
      rd_bank_reg    <= rd_bank_next;
      wr_en_reg      <= wr_en_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      frame_swap_reg <= frame_swap_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pixel_addr_next = pixel_addr_reg;
    rd_bank_next    = rd_bank_reg;
    wr_en_next      = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;
    frame_swap_next = 1'b0;
    drop_cnt_next   = drop_cnt_reg;

    case (state_reg)
      WAIT_SOF: begin
        if (cam_sof) begin
          state_next      = CAPTURE;
          pixel_addr_next = '0;
        end
      end

      CAPTURE: begin
        // The write bank is always the complement of the display bank
        if (cam_we) begin
          wr_en_next   = 1'b1;
          wr_addr_next = {~rd_bank_reg, pixel_addr_reg};
          wr_data_next = cam_pixel;
        end
        // Completing the frame takes priority over a coincident cam_sof,
        // so a back-to-back sof on the last pixel does not count as a drop.
        if (cam_we && (pixel_addr_reg == C_LAST_PXL)) begin
          state_next = FULL;
        end else if (cam_sof) begin
          pixel_addr_next = '0;
          if (drop_cnt_reg != 8'hFF) begin
            drop_cnt_next = drop_cnt_reg + 8'd1;
          end
        end else if (cam_we) begin
          pixel_addr_next = pixel_addr_reg + 1'b1;
        end
      end

      FULL: begin
        if (disp_eof) begin
          state_next = WAIT_SOF;
          // With freeze held the captured frame is discarded and the
          // write bank is simply refilled.
          if (!freeze_hold) begin
            rd_bank_next    = ~rd_bank_reg;
            frame_swap_next = 1'b1;
          end
        end
      end

      default: state_next = WAIT_SOF;
    endcase
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign rd_bank    = rd_bank_reg;
  assign frame_swap = frame_swap_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_fbuf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fbuf_pingpong_ctrl
// Self-checking bench for fbuf_pingpong_ctrl. A frame-level reference model
// (pixels received so far, whether a full frame is waiting, which bank is
// displayed) predicts the outputs each clock; directed frames cover the
// boundary cases and a randomized phase exercises mixed traffic.
// Define FBUF_FREEZE_EN to also exercise the freeze input.
// ---------------------------------------------------------------------------
module tb_fbuf_pingpong_ctrl;
  import fbuf_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cam_sof;
  logic                   cam_we;
  logic [C_NB_BUF-1:0]    cam_pixel;
  logic                   disp_eof;
  logic                   freeze;
  logic                   wr_en;
  logic [C_NB_IMG_PXLS:0] wr_addr;
  logic [C_NB_BUF-1:0]    wr_data;
  logic                   rd_bank;
  logic                   frame_swap;
  logic [7:0]             drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fbuf_pingpong_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cam_sof    (cam_sof),
    .cam_we     (cam_we),
    .cam_pixel  (cam_pixel),
    .disp_eof   (disp_eof),
`ifdef FBUF_FREEZE_EN
    .freeze     (freeze),
`endif
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_bank    (rd_bank),
    .frame_swap (frame_swap),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // received = -1 : waiting for a start of frame
  // received = n  : n pixels of the current frame already stored
  int  m_received = -1;
  bit  m_full     = 0;
  bit  m_disp     = 1;     // displayed bank; camera writes the other one
  bit  m_wr_en    = 0;
  int  m_addr     = 0;
  int  m_data     = 0;
  bit  m_swap     = 0;
  int  m_drops    = 0;
  bit  freeze_eff;

  // DUT event tallies used by the directed checks
  int  n_wr = 0, n_swap = 0, last_addr = 0;

  always @(posedge clk) begin
`ifdef FBUF_FREEZE_EN
    freeze_eff = freeze;
`else
    freeze_eff = 1'b0;
`endif
    m_wr_en = 0;
    m_swap  = 0;
    if (rst) begin
      m_received = -1; m_full = 0; m_disp = 1;
      m_addr = 0; m_data = 0; m_drops = 0;
    end else if (m_full) begin
      if (disp_eof) begin
        m_full = 0;
        m_received = -1;
        if (!freeze_eff) begin
          m_disp = !m_disp;
          m_swap = 1;
        end
      end
    end else if (m_received < 0) begin
      if (cam_sof) m_received = 0;
    end else begin
      if (cam_we) begin
        m_wr_en = 1;
        m_addr  = (m_disp ? 0 : C_IMG_PXLS * 0 + (1 << C_NB_IMG_PXLS)) + m_received;
        m_data  = int'(cam_pixel);
      end
      if (cam_we && m_received + 1 == C_IMG_PXLS) begin
        m_full = 1;
      end else if (cam_sof) begin
        m_received = 0;
        if (m_drops < 255) m_drops++;
      end else if (cam_we) begin
        m_received++;
      end
    end
    #1;
    chk("wr_en", int'(wr_en), int'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", int'(wr_addr), m_addr);
      chk("wr_data", int'(wr_data), m_data);
    end
    chk("rd_bank", int'(rd_bank), int'(m_disp));
    chk("frame_swap", int'(frame_swap), int'(m_swap));
    chk("drop_cnt", int'(drop_cnt), m_drops);
    if (wr_en) begin
      n_wr++;
      last_addr = int'(wr_addr);
    end
    if (frame_swap) n_swap++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_eof();
    disp_eof = 1'b1;
    @(negedge clk);
    disp_eof = 1'b0;
    idle(2);
  endtask

  // Send a start of frame then npx pixels (pixel value = address[11:0]),
  // with random idle gaps. Options put sof or disp_eof on the last strobe.
  task automatic send_frame(input int npx, input bit sof_on_last, input bit eof_on_last);
    logic [12:0] a;
    cam_sof = 1'b1;
    @(negedge clk);
    cam_sof = 1'b0;
    for (int i = 0; i < npx; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      a = 13'(i);
      cam_we    = 1'b1;
      cam_pixel = a[11:0];
      if (i == npx - 1) begin
        cam_sof  = sof_on_last;
        disp_eof = eof_on_last;
      end
      @(negedge clk);
      cam_we = 1'b0; cam_sof = 1'b0; disp_eof = 1'b0;
    end
    idle(2);
    $display("frame: %0d pixels sent, drop_cnt=%0d rd_bank=%0d", npx, drop_cnt, rd_bank);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  int w0, s0, exp_rd;

  initial begin
    rst = 1'b1; cam_sof = 0; cam_we = 0; cam_pixel = '0; disp_eof = 0; freeze = 0;
    idle(3);
    rst = 1'b0;
    idle(2);
    // 1. reset state
    chk("t1_rd_bank", int'(rd_bank), 1);
    chk("t1_wr_en", int'(wr_en), 0);
    chk("t1_drop_cnt", int'(drop_cnt), 0);
    chk("t1_wr_addr", int'(wr_addr), 0);
    exp_rd = 1;

    // 2. full frame into bank 0, then swap
    w0 = n_wr;
    send_frame(4800, 0, 0);
    chk("t2_writes", n_wr - w0, 4800);
    chk("t2_last_addr", last_addr, 4799);
    s0 = n_swap;
    pulse_eof();
    exp_rd = 0;
    chk("t2_swaps", n_swap - s0, 1);
    chk("t2_rd_bank", int'(rd_bank), exp_rd);

    // 3. aborted frame then full frame into bank 1
    send_frame(100, 0, 0);
    w0 = n_wr;
    send_frame(4800, 0, 0);
    chk("t3_drop_cnt", int'(drop_cnt), 1);
    chk("t3_writes", n_wr - w0, 4800);
    chk("t3_last_addr", last_addr, 8192 + 4799);
    pulse_eof();
    exp_rd = 1;
    chk("t3_rd_bank", int'(rd_bank), exp_rd);

    // 4. early disp_eof, extra strobes after the frame is full
    s0 = n_swap;
    cam_sof = 1; @(negedge clk); cam_sof = 0;
    for (int i = 0; i < 50; i++) begin cam_we = 1; @(negedge clk); end
    cam_we = 0;
    pulse_eof();
    chk("t4_early_eof_swaps", n_swap - s0, 0);
    send_frame(4800, 0, 0);   // restart counts a drop
    chk("t4_drop_cnt", int'(drop_cnt), 2);
    w0 = n_wr;
    cam_we = 1; @(negedge clk);
    cam_sof = 1; @(negedge clk);
    cam_sof = 0; repeat (3) @(negedge clk);
    cam_we = 0; idle(2);
    chk("t4_extra_writes", n_wr - w0, 0);
    pulse_eof();
    exp_rd = 0;
    chk("t4_swaps", n_swap - s0, 1);

    // 5. last write coincident with disp_eof
    s0 = n_swap;
    send_frame(4800, 0, 1);
    chk("t5_coincident_swaps", n_swap - s0, 0);
    pulse_eof();
    exp_rd = 1;
    chk("t5_swaps", n_swap - s0, 1);
    chk("t5_rd_bank", int'(rd_bank), exp_rd);

    // 5b. cam_sof on the last strobe: frame completes, no drop
    w0 = n_wr;
    send_frame(4800, 1, 0);
    chk("t5b_drop_cnt", int'(drop_cnt), 2);
    chk("t5b_writes", n_wr - w0, 4800);
    pulse_eof();
    exp_rd = 0;
    chk("t5b_rd_bank", int'(rd_bank), exp_rd);

`ifdef FBUF_FREEZE_EN
    // 6. freeze holds the displayed bank over two full frames
    freeze = 1;
    s0 = n_swap;
    send_frame(4800, 0, 0); pulse_eof();
    send_frame(4800, 0, 0); pulse_eof();
    chk("t6_frozen_swaps", n_swap - s0, 0);
    chk("t6_rd_bank", int'(rd_bank), exp_rd);
    freeze = 0;
    send_frame(4800, 0, 0); pulse_eof();
    exp_rd = 1;
    chk("t6_release_swaps", n_swap - s0, 1);
    chk("t6_rd_bank_after", int'(rd_bank), exp_rd);
`endif

    // 7. reset mid-frame abandons the frame
    cam_sof = 1; @(negedge clk); cam_sof = 0;
    for (int i = 0; i < 30; i++) begin cam_we = 1; @(negedge clk); end
    cam_we = 0;
    rst = 1; @(negedge clk); rst = 0; idle(2);
    chk("t7_rd_bank", int'(rd_bank), 1);
    chk("t7_drop_cnt", int'(drop_cnt), 0);
    chk("t7_wr_en", int'(wr_en), 0);

    // 8. randomized traffic; sof and we never share a clock here
    for (int c = 0; c < 15000; c++) begin
      cam_sof  = ($urandom_range(0, 1999) == 0);
      cam_we   = !cam_sof && ($urandom_range(0, 1) == 0);
      cam_pixel = 12'($urandom);
      disp_eof = ($urandom_range(0, 299) == 0);
`ifdef FBUF_FREEZE_EN
      freeze   = ($urandom_range(0, 3) == 0);
`endif
      @(negedge clk);
    end
    cam_sof = 0; cam_we = 0; disp_eof = 0; freeze = 0;
    idle(3);
    $display("random phase done: drop_cnt=%0d rd_bank=%0d", drop_cnt, rd_bank);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
